tb_clk_scheduler: RTL and testbench

- Synthesizable controller that sequences the test-bench DUT clock carried in `clk_ctrl_t` (fields `clk`, `nEnable`, `manual`).
- Derives a divided DUT clock from the fast bench clock and supports two modes:
  - free-running "automatic" mode;
  - "manual" mode, where a unit test requests an exact number of DUT cycles through a req/ack handshake.
- Sits between the unit-test stimulus and every DUT clock input, so all tests share one glitch-free clock source.

---
 rtl/testbench_common_pkg.sv | 26 ++
 rtl/tb_clk_half_period_timer.sv | 41 ++++
 rtl/tb_clk_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_tb_clk_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/testbench_common_pkg.sv
// -----------------------------------------------------------------------------
// testbench_common_pkg
//   Shared types for the unit-test clocking infrastructure.
//   - clk_ctrl_t            : DUT clock bundle (clock, effective nEnable,
//                             effective manual flag).
//   - tb_clk_sched_state_e  : state encoding of tb_clk_scheduler.
//   - TB_CLK_MIN_HALF_PERIOD: smallest legal phase length in bench cycles.
// -----------------------------------------------------------------------------
package testbench_common_pkg;

    typedef struct packed {
        logic clk;
        logic nEnable;
        logic manual;
    } clk_ctrl_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_AUTO = 2'd1,
        RUN_STEP = 2'd2,
        ACK      = 2'd3
    } tb_clk_sched_state_e;

    localparam int unsigned TB_CLK_MIN_HALF_PERIOD = 1;

endpackage

// File: rtl/tb_clk_half_period_timer.sv
// -----------------------------------------------------------------------------
// tb_clk_half_period_timer
//   Loadable down-counter that measures one phase of the generated DUT clock.
//   Ports:
//     clk, nRst : bench clock, asynchronous active-low reset
//     load      : start a new phase of 'period' bench cycles
//     period    : phase length; 0 is promoted to TB_CLK_MIN_HALF_PERIOD
//     expire    : high on the last bench cycle of the phase (and while idle,
//                 so the first phase after idle can start immediately)
// -----------------------------------------------------------------------------
module tb_clk_half_period_timer
    import testbench_common_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    output logic             expire
);

    localparam logic [DIV_W-1:0] MIN_P = DIV_W'(TB_CLK_MIN_HALF_PERIOD);

    logic [DIV_W-1:0] cnt;

    // After a load the counter shows period..1, so a phase lasts exactly
    // 'period' cycles; it then rests at 0.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (period < MIN_P) ? MIN_P : period;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt <= MIN_P);

endmodule

// File: rtl/tb_clk_scheduler.sv
// -----------------------------------------------------------------------------
// tb_clk_scheduler
//   Produces the glitch-free DUT clock shared by all unit tests, either
//   free-running (automatic) or as an exact number of periods (manual steps).
//   Optional feature: define TB_CLK_SCHEDULER_EDGE_CNT_EN to enable the
//   rising-edge counter on cycle_cnt_o; otherwise cycle_cnt_o is tied to 0.
//   Ports:
//     clk, nRst       : bench clock, asynchronous active-low reset
//     nEnable_i       : 1 = request stop (acted on at period boundaries)
//     manual_i        : 0 = automatic, 1 = manual stepping
//     half_period_i   : bench cycles per DUT phase (0 treated as 1)
//     step_req_i      : manual step request
//     step_cnt_i      : number of full DUT periods requested
//     step_ack_o      : one-cycle completion pulse
//     step_abort_o    : valid with step_ack_o, 1 = ended early by nEnable_i
//     busy_o          : DUT clock currently being produced
//     clk_ctrl_o      : generated clock + effective nEnable/manual
//     cycle_cnt_o     : DUT rising edges since reset (wraps)
//     state_o         : current FSM state, for observation
//   Handshake: step_req_i is a level that the requester holds high until it
//   sees step_ack_o; the request is served once, and a further request is
//   accepted only after step_req_i has been seen low for at least one cycle.
//   All outputs are registered.
// -----------------------------------------------------------------------------
module tb_clk_scheduler
    import testbench_common_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                nEnable_i,
    input  logic                manual_i,
    input  logic [DIV_W-1:0]    half_period_i,
    input  logic                step_req_i,
    input  logic [STEP_W-1:0]   step_cnt_i,
    output logic                step_ack_o,
    output logic                step_abort_o,
    output logic                busy_o,
    output clk_ctrl_t           clk_ctrl_o,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output tb_clk_sched_state_e state_o
);

    tb_clk_sched_state_e state, state_n;
    logic                gclk, gclk_n;
    logic                nen_q, nen_n;
    logic                man_q, man_n;
    logic [STEP_W-1:0]   rem, rem_n;
    logic                abort_pend, abort_pend_n;
    logic                armed, armed_n;
    logic                ack_q, ack_n;
    logic                abort_q, abort_n;
    logic                busy_q, busy_n;
    logic                rise, fall;
    logic                expire;

    tb_clk_half_period_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk    (clk),
        .nRst   (nRst),
        .load   (rise | fall),
        .period (half_period_i),
        .expire (expire)
    );

    always_comb begin
        state_n      = state;
        rem_n        = rem;
        abort_pend_n = abort_pend;
        armed_n      = armed | ~step_req_i;
        ack_n        = 1'b0;
        abort_n      = 1'b0;
        nen_n        = nen_q;
        man_n        = man_q;
        rise         = 1'b0;
        fall         = 1'b0;

        case (state)
            IDLE: begin
                nen_n        = nEnable_i;
                man_n        = manual_i;
                abort_pend_n = 1'b0;
                if (!nEnable_i && !manual_i) begin
                    state_n = RUN_AUTO;
                end else if (!nEnable_i && manual_i && step_req_i && armed) begin
                    armed_n = 1'b0;
                    if (step_cnt_i == '0) begin
                        ack_n = 1'b1;
                    end else begin
                        rem_n   = step_cnt_i;
                        state_n = RUN_STEP;
                    end
                end
            end

            RUN_AUTO: begin
                if (expire) begin
                    if (gclk) begin
                        fall = 1'b1;
                    end else begin
                        // Period boundary: the only place mode changes apply.
                        nen_n = nEnable_i;
                        man_n = manual_i;
                        if (nEnable_i || manual_i) begin
                            state_n = IDLE;
                        end else begin
                            rise = 1'b1;
                        end
                    end
                end
            end

            RUN_STEP: begin
                // A stop request is remembered but only honoured once the
                // period in flight has completed.
                if (nEnable_i) begin
                    abort_pend_n = 1'b1;
                end
                if (expire) begin
                    if (gclk) begin
                        fall = 1'b1;
                    end else begin
                        nen_n = nEnable_i;
                        if (rem == '0 || abort_pend || nEnable_i) begin
                            state_n = ACK;
                            ack_n   = 1'b1;
                            abort_n = (rem != '0);
                        end else begin
                            rise  = 1'b1;
                            rem_n = rem - 1'b1;
                        end
                    end
                end
            end

            ACK: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        gclk_n = gclk;
        if (rise) begin
            gclk_n = 1'b1;
        end else if (fall) begin
            gclk_n = 1'b0;
        end

        busy_n = (state_n == RUN_AUTO) || (state_n == RUN_STEP);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            gclk       <= 1'b0;
            nen_q      <= 1'b1;
            man_q      <= 1'b0;
            rem        <= '0;
            abort_pend <= 1'b0;
            armed      <= 1'b1;
            ack_q      <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            gclk       <= gclk_n;
            nen_q      <= nen_n;
            man_q      <= man_n;
            rem        <= rem_n;
            abort_pend <= abort_pend_n;
            armed      <= armed_n;
            ack_q      <= ack_n;
            abort_q    <= abort_n;
            busy_q     <= busy_n;
        end
    end

`ifdef TB_CLK_SCHEDULER_EDGE_CNT_EN
    logic [CNT_W-1:0] edge_cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            edge_cnt <= '0;
        end else if (rise) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    assign cycle_cnt_o = edge_cnt;
`else
    assign cycle_cnt_o = '0;
`endif

    assign clk_ctrl_o.clk     = gclk;
    assign clk_ctrl_o.nEnable = nen_q;
    assign clk_ctrl_o.manual  = man_q;
    assign step_ack_o         = ack_q;
    assign step_abort_o       = abort_q;
    assign busy_o             = busy_q;
    assign state_o            = state;

endmodule

// File: tb/tb_tb_clk_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tb_clk_scheduler
//   Self-checking bench for tb_clk_scheduler. Expected step acknowledgements
//   ({abort, rising edges since request}) are queued when a request is
//   issued and popped by the monitor whenever step_ack_o pulses. The monitor
//   also logs the length of every generated clock phase for phase checks.
// -----------------------------------------------------------------------------
module tb_tb_clk_scheduler;
    import testbench_common_pkg::*;

`ifdef TB_CLK_SCHEDULER_EDGE_CNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic                clk = 1'b0;
    logic                nRst;
    logic                nEnable_i;
    logic                manual_i;
    logic [7:0]          half_period_i;
    logic                step_req_i;
    logic [15:0]         step_cnt_i;
    logic                step_ack_o;
    logic                step_abort_o;
    logic                busy_o;
    clk_ctrl_t           clk_ctrl_o;
    logic [31:0]         cycle_cnt_o;
    tb_clk_sched_state_e state_o;

    always #5 clk = ~clk;

    tb_clk_scheduler dut (
        .clk           (clk),
        .nRst          (nRst),
        .nEnable_i     (nEnable_i),
        .manual_i      (manual_i),
        .half_period_i (half_period_i),
        .step_req_i    (step_req_i),
        .step_cnt_i    (step_cnt_i),
        .step_ack_o    (step_ack_o),
        .step_abort_o  (step_abort_o),
        .busy_o        (busy_o),
        .clk_ctrl_o    (clk_ctrl_o),
        .cycle_cnt_o   (cycle_cnt_o),
        .state_o       (state_o)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [16:0] exp_q[$];
    int          phase_log[$];
    int          exp_phase[$];
    int          edges     = 0;
    int          edge_mark = 0;
    logic        prev_g    = 1'b0;
    int          run_len   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cc(input int n);
        return CC_EN ? 32'(n) : 32'd0;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [16:0] act;
        logic [16:0] e;
        if (!nRst) begin
            prev_g  = 1'b0;
            run_len = 0;
        end else begin
            if (clk_ctrl_o.clk !== prev_g) begin
                phase_log.push_back(run_len);
                if (clk_ctrl_o.clk === 1'b1) edges++;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_g = clk_ctrl_o.clk;
            if (step_ack_o === 1'b1) begin
                act = {step_abort_o, 16'(edges - edge_mark)};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_ack: got abort=%0d edges=%0d expected no ack", act[16], act[15:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_miss++;
                        $display("FAIL step_ack: got abort=%0d edges=%0d expected abort=%0d edges=%0d",
                                 act[16], act[15:0], e[16], e[15:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_edges(input string name, input int n, input int budget);
        int c = 0;
        while ((edges - edge_mark) < n && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(edges - edge_mark), 64'(n));
    endtask

    task automatic wait_ack(input string name, input int budget, output int lat);
        int c = 0;
        do begin
            tick();
            c++;
        end while (step_ack_o !== 1'b1 && c < budget);
        check(name, 64'(step_ack_o), 64'd1);
        lat = c;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (busy_o !== 1'b0 && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(busy_o), 64'd0);
    endtask

    task automatic start_phase_log();
        phase_log.delete();
        exp_phase.delete();
        edge_mark = edges;
    endtask

    // Entry 0 of the log is the idle time before the first edge; skip it.
    task automatic check_phases(input string name);
        int bad = 0;
        check({name, "_phase_count"}, 64'(phase_log.size()), 64'(exp_phase.size() + 1));
        foreach (exp_phase[i]) begin
            if (i + 1 < phase_log.size() && phase_log[i + 1] != exp_phase[i]) bad++;
        end
        check({name, "_phase_len_errors"}, 64'(bad), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        nRst          = 1'b0;
        nEnable_i     = 1'b1;
        manual_i      = 1'b0;
        half_period_i = 8'd4;
        step_req_i    = 1'b0;
        step_cnt_i    = '0;
        repeat (3) tick();
        nRst = 1'b1;

        // Reset values
        check("rst_clk",     64'(clk_ctrl_o.clk), 64'd0);
        check("rst_nenable", 64'(clk_ctrl_o.nEnable), 64'd1);
        check("rst_manual",  64'(clk_ctrl_o.manual), 64'd0);
        check("rst_ack",     64'(step_ack_o), 64'd0);
        check("rst_abort",   64'(step_abort_o), 64'd0);
        check("rst_busy",    64'(busy_o), 64'd0);
        check("rst_cnt",     64'(cycle_cnt_o), 64'd0);
        check("rst_state",   64'(state_o), 64'(IDLE));

        // 1: automatic, half period 4 -> period 8, 100 periods
        start_phase_log();
        nEnable_i = 1'b0;
        wait_edges("t1_edges", 100, 1000);
        check("t1_busy",    64'(busy_o), 64'd1);
        check("t1_cnt",     64'(cycle_cnt_o), 64'(exp_cc(100)));
        check("t1_nenable", 64'(clk_ctrl_o.nEnable), 64'd0);
        check("t1_manual",  64'(clk_ctrl_o.manual), 64'd0);
        nEnable_i = 1'b1;
        wait_idle("t1_stop", 20);
        check("t1_clk_low", 64'(clk_ctrl_o.clk), 64'd0);
        check("t1_edges_after_stop", 64'(edges - edge_mark), 64'd100);
        for (int i = 0; i < 199; i++) exp_phase.push_back(4);
        check_phases("t1");

        // 2: manual, 5 steps at half period 2
        manual_i = 1'b1;
        tick();
        nEnable_i     = 1'b0;
        half_period_i = 8'd2;
        step_cnt_i    = 16'd5;
        tick();
        start_phase_log();
        exp_q.push_back({1'b0, 16'd5});
        step_req_i = 1'b1;
        wait_ack("t2_ack", 200, lat);
        step_req_i = 1'b0;
        repeat (10) tick();
        check("t2_clk_low",  64'(clk_ctrl_o.clk), 64'd0);
        check("t2_edges",    64'(edges - edge_mark), 64'd5);
        check("t2_busy",     64'(busy_o), 64'd0);
        check("t2_cnt",      64'(cycle_cnt_o), 64'(exp_cc(105)));
        check("t2_manual",   64'(clk_ctrl_o.manual), 64'd1);
        for (int i = 0; i < 9; i++) exp_phase.push_back(2);
        check_phases("t2");

        // 3: zero-length request acknowledged on the next cycle
        step_cnt_i = 16'd0;
        start_phase_log();
        exp_q.push_back({1'b0, 16'd0});
        step_req_i = 1'b1;
        wait_ack("t3_ack", 5, lat);
        check("t3_ack_latency", 64'(lat), 64'd1);
        step_req_i = 1'b0;
        repeat (5) tick();
        check("t3_edges", 64'(edges - edge_mark), 64'd0);
        check("t3_cnt",   64'(cycle_cnt_o), 64'(exp_cc(105)));

        // 4: 10 requested, stop raised mid high phase after three full
        //    periods (fourth high phase) -> that period completes, abort
        half_period_i = 8'd3;
        step_cnt_i    = 16'd10;
        tick();
        start_phase_log();
        exp_q.push_back({1'b1, 16'd4});
        step_req_i = 1'b1;
        wait_edges("t4_edges_before_stop", 4, 200);
        tick();
        nEnable_i = 1'b1;
        wait_ack("t4_ack", 50, lat);
        step_req_i = 1'b0;
        repeat (5) tick();
        check("t4_edges", 64'(edges - edge_mark), 64'd4);
        check("t4_cnt",   64'(cycle_cnt_o), 64'(exp_cc(109)));
        for (int i = 0; i < 7; i++) exp_phase.push_back(3);
        check_phases("t4");

        // 5: automatic, half period 3 changed to 1 in the middle of a phase
        manual_i = 1'b0;
        tick();
        start_phase_log();
        nEnable_i = 1'b0;
        wait_edges("t5_edges_first", 2, 100);
        tick();
        half_period_i = 8'd1;
        wait_edges("t5_edges_total", 6, 100);
        nEnable_i = 1'b1;
        wait_idle("t5_stop", 20);
        check("t5_cnt", 64'(cycle_cnt_o), 64'(exp_cc(115)));
        for (int i = 0; i < 3; i++) exp_phase.push_back(3);
        for (int i = 0; i < 8; i++) exp_phase.push_back(1);
        check_phases("t5");

        // 6: reset while the clock is high during a manual step
        manual_i      = 1'b1;
        half_period_i = 8'd5;
        step_cnt_i    = 16'd8;
        tick();
        nEnable_i = 1'b0;
        start_phase_log();
        step_req_i = 1'b1;
        wait_edges("t6_edges", 2, 100);
        check("t6_clk_high_before", 64'(clk_ctrl_o.clk), 64'd1);
        check("t6_cnt_before",      64'(cycle_cnt_o), 64'(exp_cc(117)));
        nRst = 1'b0;
        #1;
        check("t6_clk",     64'(clk_ctrl_o.clk), 64'd0);
        check("t6_nenable", 64'(clk_ctrl_o.nEnable), 64'd1);
        check("t6_manual",  64'(clk_ctrl_o.manual), 64'd0);
        check("t6_busy",    64'(busy_o), 64'd0);
        check("t6_ack",     64'(step_ack_o), 64'd0);
        check("t6_cnt",     64'(cycle_cnt_o), 64'd0);
        check("t6_state",   64'(state_o), 64'(IDLE));
        step_req_i = 1'b0;
        nEnable_i  = 1'b1;
        repeat (2) tick();
        nRst = 1'b1;
        repeat (5) tick();
        check("t6_state_after", 64'(state_o), 64'(IDLE));
        check("t6_clk_after",   64'(clk_ctrl_o.clk), 64'd0);

        check("pending_acks", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #1ms;
        n_miss++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog expired");
    end

endmodule
